onehot_index_encoder: RTL



---
 rtl/onehot_index_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/onehot_index_encoder.sv
// One-hot to binary index encoder with valid/ready handshake on both sides.
// Main output register plus one skid register keeps in_ready purely registered.
module onehot_index_encoder #(
  parameter  int N  = 8,
  parameter  int CW = 8,
  localparam int W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_onehot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_index,
  output logic          out_error,
  output logic [CW-1:0] err_count,
  input  logic          clr_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_idx_q, skid_idx_q;
  logic           main_err_q, skid_err_q;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   enc_idx;
  logic           enc_err;
  logic           found, multi;
  logic           accept, xfer;
  logic           load_main, load_skid, shift_skid;

  // Lowest set bit wins; zero or multiple set bits flag an error.
  always_comb begin
    enc_idx = '0;
    enc_err = 1'b1;
    found   = 1'b0;
    multi   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_onehot[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          enc_idx = W'(i);
          found   = 1'b1;
        end
      end
    end
    enc_err = !found || multi;
  end

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !xfer)      state_d = TWO;
        else if (!accept && xfer) state_d = EMPTY;
      end
      TWO:   if (xfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Illegal state refuses input so no word is lost while it recovers to EMPTY.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; end
      ONE:   begin in_ready = 1'b1; out_valid = 1'b1; end
      TWO:   begin in_ready = 1'b0; out_valid = 1'b1; end
      default: begin in_ready = 1'b0; out_valid = 1'b0; end
    endcase
  end

  assign load_main  = accept && ((state_q == EMPTY) || ((state_q == ONE) && xfer));
  assign load_skid  = accept && (state_q == ONE) && !xfer;
  assign shift_skid = (state_q == TWO) && xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_idx_q <= '0;
      main_err_q <= 1'b0;
      skid_idx_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (load_main) begin
        main_idx_q <= enc_idx;
        main_err_q <= enc_err;
      end else if (shift_skid) begin
        main_idx_q <= skid_idx_q;
        main_err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_idx_q <= enc_idx;
        skid_err_q <= enc_err;
      end
    end
  end

  assign out_index = main_idx_q;
  assign out_error = main_err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)                                   cnt_d = '0;
    else if (accept && enc_err && (cnt_q != '1))     cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;

endmodule
